hasty_flow_sequencer: RTL and testbench

- Digital controller that drives the five fluidic ports of the 8-trap hasty device: inlet valves, outlet valves, pump enable and pump direction.
- Runs the timed protocol that fills the traps through the splitter tree (p1..p3 side). It also drives the device the other way, eluting back from the recombining tree (p4/p5 side) to p1.
- Sits between the host control register block and the valve/pump driver pins.

---
 rtl/hasty_pkg.sv | 39 +++
 rtl/hasty_phase_timer.sv | 46 ++++
 rtl/hasty_flow_sequencer.sv | 164 ++++++++++++++++
 tb/tb_hasty_flow_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hasty_pkg.sv
// Shared definitions for the hasty device flow sequencer: state encoding,
// fluidic port bit positions and the fixed valve patterns.
package hasty_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRIME    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_INCUBATE = 3'd3,
    ST_WASH     = 3'd4,
    ST_ELUTE    = 3'd5,
    ST_SETTLE   = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int P3_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int P5_IDX = 4;

  // p1 in, p4 out (forward fill of the splitter tree)
  localparam logic [4:0] VALVES_PRIME = (5'b1 << P1_IDX) | (5'b1 << P4_IDX);
  // p1 in, p5 out
  localparam logic [4:0] VALVES_WASH  = (5'b1 << P1_IDX) | (5'b1 << P5_IDX);
  // p4 in, p1 out; same ports as PRIME, the pump direction differs
  localparam logic [4:0] VALVES_ELUTE = (5'b1 << P1_IDX) | (5'b1 << P4_IDX);

  // Reagent inlet (p2 or p3) plus the p5 outlet
  function automatic logic [4:0] valves_load(input logic sel);
    logic [4:0] v;
    v = 5'b0;
    v[P5_IDX] = 1'b1;
    if (sel) v[P3_IDX] = 1'b1;
    else     v[P2_IDX] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hasty_phase_timer.sv
// Phase duration timer: prescaler plus tick counter. In cycle mode every
// clock counts as a tick, which is how the SETTLE dead time is measured.
module hasty_phase_timer import hasty_pkg::*; #(
  parameter int TICK_W   = 16,
  parameter int PRESCALE = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_cycle_mode,
  input  logic [TICK_W-1:0] i_limit,
  output logic              o_expired
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]   r_ps;
  logic [TICK_W-1:0] r_tick;
  logic              w_tick_end;
  logic              w_last_tick;

  assign w_tick_end  = i_cycle_mode || (r_ps == PS_LAST);
  assign w_last_tick = (r_tick == (i_limit - TICK_W'(1)));
  // A zero limit expires immediately so the phase lasts a single cycle
  assign o_expired   = (i_limit == '0) || (w_last_tick && w_tick_end);

  // Count up from zero after each clear; hold once expired so nothing wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ps   <= '0;
      r_tick <= '0;
    end else if (i_clear) begin
      r_ps   <= '0;
      r_tick <= '0;
    end else if (!o_expired) begin
      if (w_tick_end) begin
        r_ps   <= '0;
        r_tick <= r_tick + TICK_W'(1);
      end else begin
        r_ps   <= r_ps + PS_W'(1);
      end
    end
  end

endmodule

// File: rtl/hasty_flow_sequencer.sv
// Fluidic protocol sequencer for the 8-trap hasty device: prime, load,
// incubate/wash passes and reverse elution, with all-closed settle gaps.
module hasty_flow_sequencer import hasty_pkg::*; #(
  parameter int TICK_W     = 16,
  parameter int PRESCALE   = 1000,
  parameter int SETTLE_CYC = 8,
  parameter int REP_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TICK_W-1:0] cfg_prime_ticks,
  input  logic [TICK_W-1:0] cfg_load_ticks,
  input  logic [TICK_W-1:0] cfg_incubate_ticks,
  input  logic [TICK_W-1:0] cfg_wash_ticks,
  input  logic [TICK_W-1:0] cfg_elute_ticks,
  input  logic              cfg_reagent_sel,
  input  logic [REP_W-1:0]  cfg_repeats,
  input  logic [7:0]        trap_occupied,
  output logic [4:0]        valve_en,
  output logic              pump_en,
  output logic              pump_rev,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        phase
);

  state_t            r_state, r_ret;
  state_t            w_next, w_ret_next;
  logic [REP_W-1:0]  r_rep;
  logic [7:0]        r_sync1, r_sync2;
  logic [4:0]        r_valve, w_valve;
  logic              r_pump_en, r_pump_rev, w_pump_en, w_pump_rev;
  logic              r_done, r_aborted;
  logic [TICK_W-1:0] r_cfg_prime, r_cfg_load, r_cfg_inc, r_cfg_wash, r_cfg_elute;
  logic              r_cfg_sel;
  logic [REP_W-1:0]  r_cfg_rep;
  logic [TICK_W-1:0] w_limit;
  logic              w_accept, w_expired, w_clear, w_phase_exit;

  assign w_accept     = (r_state == ST_IDLE) && start && !abort;
  assign w_clear      = (w_next != r_state) || (r_state == ST_IDLE);
  assign w_phase_exit = (w_next == ST_SETTLE) && (r_state != ST_SETTLE);

  // Duration source for the current phase
  always_comb begin
    w_limit = '0;
    case (r_state)
      ST_PRIME:    w_limit = r_cfg_prime;
      ST_LOAD:     w_limit = r_cfg_load;
      ST_INCUBATE: w_limit = r_cfg_inc;
      ST_WASH:     w_limit = r_cfg_wash;
      ST_ELUTE:    w_limit = r_cfg_elute;
      ST_SETTLE:   w_limit = TICK_W'(SETTLE_CYC);
      default:     w_limit = '0;
    endcase
  end

  hasty_phase_timer #(
    .TICK_W   (TICK_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_cycle_mode (r_state == ST_SETTLE),
    .i_limit      (w_limit),
    .o_expired    (w_expired)
  );

  // Next state; every active phase exits through SETTLE, which then jumps to r_ret
  always_comb begin
    w_next     = r_state;
    w_ret_next = r_ret;
    if ((r_state != ST_IDLE) && abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (w_accept) w_next = ST_PRIME;
        ST_PRIME:    if (w_expired) begin w_next = ST_SETTLE; w_ret_next = ST_LOAD; end
        ST_LOAD:     if (w_expired || (r_sync2 == 8'hFF)) begin
                       w_next = ST_SETTLE; w_ret_next = ST_INCUBATE;
                     end
        ST_INCUBATE: if (w_expired) begin w_next = ST_SETTLE; w_ret_next = ST_WASH; end
        ST_WASH:     if (w_expired) begin
                       w_next     = ST_SETTLE;
                       w_ret_next = (r_rep != '0) ? ST_INCUBATE : ST_ELUTE;
                     end
        ST_ELUTE:    if (w_expired) begin w_next = ST_SETTLE; w_ret_next = ST_DONE; end
        ST_SETTLE:   if (w_expired) w_next = r_ret;
        ST_DONE:     w_next = ST_IDLE;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  // Drive pattern of the state being entered, so outputs are registered
  always_comb begin
    w_valve    = 5'b0;
    w_pump_en  = 1'b0;
    w_pump_rev = 1'b0;
    case (w_next)
      ST_PRIME: begin w_valve = VALVES_PRIME; w_pump_en = 1'b1; end
      ST_LOAD:  begin w_valve = valves_load(r_cfg_sel); w_pump_en = 1'b1; end
      ST_WASH:  begin w_valve = VALVES_WASH; w_pump_en = 1'b1; end
      ST_ELUTE: begin w_valve = VALVES_ELUTE; w_pump_en = 1'b1; w_pump_rev = 1'b1; end
      default:  ;
    endcase
  end

  // State, outputs, repeat counter and sensor synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ret      <= ST_IDLE;
      r_rep      <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_valve    <= '0;
      r_pump_en  <= 1'b0;
      r_pump_rev <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ret      <= w_ret_next;
      r_sync1    <= trap_occupied;
      r_sync2    <= r_sync1;
      r_valve    <= w_valve;
      r_pump_en  <= w_pump_en;
      r_pump_rev <= w_pump_rev;
      r_done     <= (r_state == ST_DONE) && !abort;
      r_aborted  <= (r_state != ST_IDLE) && abort;
      if (w_phase_exit && (r_state == ST_LOAD))
        r_rep <= r_cfg_rep;
      else if (w_phase_exit && (r_state == ST_WASH) && (r_rep != '0))
        r_rep <= r_rep - REP_W'(1);
    end
  end

  // Configuration snapshot taken only when a run is accepted
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cfg_prime <= cfg_prime_ticks;
      r_cfg_load  <= cfg_load_ticks;
      r_cfg_inc   <= cfg_incubate_ticks;
      r_cfg_wash  <= cfg_wash_ticks;
      r_cfg_elute <= cfg_elute_ticks;
      r_cfg_sel   <= cfg_reagent_sel;
      r_cfg_rep   <= cfg_repeats;
    end
  end

  assign valve_en = r_valve;
  assign pump_en  = r_pump_en;
  assign pump_rev = r_pump_rev;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign aborted  = r_aborted;
  assign phase    = r_state;

endmodule

// File: tb/tb_hasty_flow_sequencer.sv
// Scoreboard bench for hasty_flow_sequencer: stimulus queues the expected
// phase segments and pulses, a negedge monitor closes segments and compares.
module tb_hasty_flow_sequencer;

  localparam int TICK_W = 16, PRESCALE = 4, SETTLE_CYC = 2, REP_W = 4;
  localparam logic [2:0] PH_IDLE = 3'd0, PH_PRIME = 3'd1, PH_LOAD = 3'd2,
                         PH_INC = 3'd3, PH_WASH = 3'd4, PH_ELUTE = 3'd5,
                         PH_SETTLE = 3'd6, PH_DONE = 3'd7;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [TICK_W-1:0] cfg_prime_ticks = '0, cfg_load_ticks = '0, cfg_incubate_ticks = '0;
  logic [TICK_W-1:0] cfg_wash_ticks = '0, cfg_elute_ticks = '0;
  logic cfg_reagent_sel = 1'b0;
  logic [REP_W-1:0] cfg_repeats = '0;
  logic [7:0] trap_occupied = 8'h00;
  logic [4:0] valve_en;
  logic pump_en, pump_rev, busy, done, aborted;
  logic [2:0] phase;

  hasty_flow_sequencer #(.TICK_W(TICK_W), .PRESCALE(PRESCALE), .SETTLE_CYC(SETTLE_CYC), .REP_W(REP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_prime_ticks(cfg_prime_ticks), .cfg_load_ticks(cfg_load_ticks),
    .cfg_incubate_ticks(cfg_incubate_ticks), .cfg_wash_ticks(cfg_wash_ticks),
    .cfg_elute_ticks(cfg_elute_ticks), .cfg_reagent_sel(cfg_reagent_sel),
    .cfg_repeats(cfg_repeats), .trap_occupied(trap_occupied),
    .valve_en(valve_en), .pump_en(pump_en), .pump_rev(pump_rev),
    .busy(busy), .done(done), .aborted(aborted), .phase(phase));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [2:0] ph; int len; logic [4:0] v; logic pe; logic pr; } seg_t;
  seg_t exp_q[$];
  logic pulse_q[$];   // 1 = done expected, 0 = aborted expected
  int checks = 0, errors = 0;

  // Monitor: one segment per contiguous non-IDLE phase, one entry per pulse
  logic [2:0] m_ph = 3'd0;
  int m_len = 0;
  logic [4:0] m_v = '0;
  logic m_pe = 1'b0, m_pr = 1'b0, m_stable = 1'b1, m_exp_p;
  seg_t m_e;
  always @(negedge clk) begin
    if (phase !== m_ph) begin
      if (m_ph != PH_IDLE) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL seg_unexpected: got ph=%0d len=%0d v=%b, required no segment", m_ph, m_len, m_v);
        end else begin
          m_e = exp_q.pop_front();
          if (m_ph != m_e.ph || m_len != m_e.len || m_v != m_e.v || m_pe != m_e.pe ||
              m_pr != m_e.pr || !m_stable) begin
            errors++;
            $display("FAIL seg: got ph=%0d len=%0d v=%b pe=%b pr=%b stable=%b, required ph=%0d len=%0d v=%b pe=%b pr=%b",
                     m_ph, m_len, m_v, m_pe, m_pr, m_stable, m_e.ph, m_e.len, m_e.v, m_e.pe, m_e.pr);
          end
        end
      end
      m_ph = phase; m_len = 1; m_v = valve_en; m_pe = pump_en; m_pr = pump_rev; m_stable = 1'b1;
    end else begin
      m_len++;
      if ({valve_en, pump_en, pump_rev} !== {m_v, m_pe, m_pr}) m_stable = 1'b0;
    end
    if (done === 1'b1 || aborted === 1'b1) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got done=%b aborted=%b, required none", done, aborted);
      end else begin
        m_exp_p = pulse_q.pop_front();
        if (done !== m_exp_p || aborted !== !m_exp_p) begin
          errors++;
          $display("FAIL pulse: got done=%b aborted=%b, required done=%b aborted=%b", done, aborted, m_exp_p, !m_exp_p);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] ph, input int len, input logic [4:0] v, input logic pe, input logic pr);
    seg_t s;
    s.ph = ph; s.len = len; s.v = v; s.pe = pe; s.pr = pr;
    exp_q.push_back(s);
  endtask

  task automatic push_settle();
    push(PH_SETTLE, SETTLE_CYC, 5'b00000, 1'b0, 1'b0);
  endtask

  // Expected full run, with hand-computed cycle lengths per active phase
  task automatic push_run(input int lp, input int ll, input int li, input int lw, input int le,
                          input int reps, input logic sel);
    push(PH_PRIME, lp, 5'b01001, 1'b1, 1'b0); push_settle();
    push(PH_LOAD, ll, sel ? 5'b10100 : 5'b10010, 1'b1, 1'b0); push_settle();
    for (int i = 0; i <= reps; i++) begin
      push(PH_INC, li, 5'b00000, 1'b0, 1'b0); push_settle();
      push(PH_WASH, lw, 5'b10001, 1'b1, 1'b0); push_settle();
    end
    push(PH_ELUTE, le, 5'b01001, 1'b1, 1'b1); push_settle();
    push(PH_DONE, 1, 5'b00000, 1'b0, 1'b0);
    pulse_q.push_back(1'b1);
  endtask

  task automatic set_cfg(input int p, input int l, input int i, input int w, input int e,
                         input int r, input logic sel);
    cfg_prime_ticks = TICK_W'(p); cfg_load_ticks = TICK_W'(l); cfg_incubate_ticks = TICK_W'(i);
    cfg_wash_ticks = TICK_W'(w); cfg_elute_ticks = TICK_W'(e); cfg_repeats = REP_W'(r);
    cfg_reagent_sel = sel;
  endtask

  // Returns the cycle counter value of the cycle in which start is high
  task automatic pulse_start(output int c);
    @(negedge clk); start = 1'b1; c = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] p, input int max);
    int n = 0;
    while (phase !== p && n < max) begin @(negedge clk); n++; end
    if (phase !== p) begin
      checks++; errors++;
      $display("FAIL wait_phase: got phase %0d, required %0d within %0d cycles", phase, p, max);
    end
  endtask

  task automatic run_wait(input int max, output int at);
    int n = 0;
    at = -1;
    while (done !== 1'b1 && n < max) begin @(negedge clk); n++; end
    if (done === 1'b1) at = cyc;
    else begin
      checks++; errors++;
      $display("FAIL run_timeout: got no done in %0d cycles, required done", max);
    end
    @(negedge clk);
  endtask

  initial begin
    int c, at, nonidle;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {24'd0, valve_en, pump_en, pump_rev, busy}, 32'd0);
    chk("reset_flags", {27'd0, done, aborted, phase}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal run; cfg changes after acceptance must not matter
    set_cfg(3, 5, 2, 1, 2, 0, 1'b0);
    push_run(12, 20, 8, 4, 8, 0, 1'b0);
    pulse_start(c);
    set_cfg(9, 1, 1, 1, 1, 3, 1'b1);
    run_wait(500, at);
    chk("nominal_done_cycle", at - c, 64);

    // Early LOAD exit once all traps report occupied
    set_cfg(1, 100, 0, 0, 0, 0, 1'b1);
    push_run(4, 8, 1, 1, 1, 0, 1'b1);
    pulse_start(c);
    wait_phase(PH_LOAD, 50);
    repeat (5) @(negedge clk);
    trap_occupied = 8'hFF;
    wait_phase(PH_SETTLE, 50);
    trap_occupied = 8'h7F;
    run_wait(200, at);
    trap_occupied = 8'h00;
    repeat (3) @(negedge clk);

    // Three incubate/wash passes
    set_cfg(0, 1, 1, 0, 1, 2, 1'b0);
    push_run(1, 4, 4, 1, 4, 2, 1'b0);
    pulse_start(c);
    run_wait(500, at);

    // Zero-duration phases
    set_cfg(0, 0, 0, 0, 0, 0, 1'b0);
    push_run(1, 1, 1, 1, 1, 0, 1'b0);
    pulse_start(c);
    wait_phase(PH_DONE, 40);
    chk("zero_done_state_cycle", cyc - c, 16);
    run_wait(40, at);

    // Abort mid-WASH
    set_cfg(0, 0, 0, 5, 0, 0, 1'b0);
    push(PH_PRIME, 1, 5'b01001, 1'b1, 1'b0); push_settle();
    push(PH_LOAD, 1, 5'b10010, 1'b1, 1'b0); push_settle();
    push(PH_INC, 1, 5'b00000, 1'b0, 1'b0); push_settle();
    push(PH_WASH, 4, 5'b10001, 1'b1, 1'b0);
    pulse_q.push_back(1'b0);
    pulse_start(c);
    wait_phase(PH_WASH, 40);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_next_cycle", {25'd0, valve_en, pump_en, busy, aborted}, {25'd0, 5'b00000, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("abort_pulse_width", {31'd0, aborted}, 32'd0);

    // Restart after abort with p3 reagent inlet
    set_cfg(0, 0, 0, 0, 0, 0, 1'b1);
    push_run(1, 1, 1, 1, 1, 0, 1'b1);
    pulse_start(c);
    wait_phase(PH_LOAD, 20);
    chk("restart_load_valves", {27'd0, valve_en}, {27'd0, 5'b10100});
    run_wait(40, at);

    // Asynchronous reset during ELUTE
    set_cfg(0, 0, 0, 0, 10, 0, 1'b0);
    push(PH_PRIME, 1, 5'b01001, 1'b1, 1'b0); push_settle();
    push(PH_LOAD, 1, 5'b10010, 1'b1, 1'b0); push_settle();
    push(PH_INC, 1, 5'b00000, 1'b0, 1'b0); push_settle();
    push(PH_WASH, 1, 5'b10001, 1'b1, 1'b0); push_settle();
    push(PH_ELUTE, 3, 5'b01001, 1'b1, 1'b1);
    pulse_start(c);
    wait_phase(PH_ELUTE, 40);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {22'd0, valve_en, pump_en, pump_rev, busy, done, aborted, phase}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Start while busy is ignored, including its new config
    set_cfg(5, 0, 0, 0, 0, 0, 1'b0);
    push_run(20, 1, 1, 1, 1, 0, 1'b0);
    pulse_start(c);
    repeat (4) @(negedge clk);
    set_cfg(1, 2, 2, 2, 2, 1, 1'b1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    run_wait(200, at);

    // start with abort in IDLE: nothing starts, no pulse
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    nonidle = 0;
    repeat (6) begin
      if (busy !== 1'b0 || phase !== PH_IDLE || aborted !== 1'b0) nonidle++;
      @(negedge clk);
    end
    chk("start_abort_idle", nonidle, 0);

    chk("seg_queue_drained", exp_q.size(), 0);
    chk("pulse_queue_drained", pulse_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
